mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- EX-stage multiply/divide unit that owns the HI and LO architectural registers.
- Executes mult, multu, div, divu, mthi and mtlo. Multiply and divide ops have multi-cycle latency.
- Its HI/LO outputs feed the EX-stage HI/LO select mux for mfhi/mflo.
- The hazard unit stalls dependent instructions using start and busy.

Parameters:
- MULT_CYCLES, 5, cycles from start to HI/LO update for mult/multu (min 1).
- DIV_CYCLES, 10, cycles from start to HI/LO update for div/divu (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  operation in EX: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, others none (see Optional Feature).
- flush  input  1  EX instruction is cancelled (exception/interrupt); md_op ignored this cycle.
- ALU_RD1  input  32  forwarded rs value (multiplicand/dividend, mthi/mtlo source).
- ALU_RD2  input  32  forwarded rt value (multiplier/divisor).
- start  output  1  combinational: md_op is mult/div class, not busy, not flush.
- busy  output  1  registered: an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on port reset.
- Reset state: while reset is high at a rising edge, HI=0, LO=0, busy=0, and the internal counter and pending result are cleared. Reset during an operation aborts it and no result is committed.
- Acceptance:
  - An op is accepted only when busy=0 and flush=0.
  - While busy=1, any md_op (including mthi/mtlo) is ignored. The pipeline stalls it upstream and re-presents it.
- mthi/mtlo: when accepted, HI (or LO) := ALU_RD1 at the next edge. Single cycle; busy stays 0.
- Mult/div start:
  - On the accepting edge: operands are captured, counter := MULT_CYCLES or DIV_CYCLES, busy := 1.
  - Later changes on ALU_RD1/ALU_RD2 have no effect.
- States: IDLE (busy=0) and RUN (busy=1).
  - In RUN the counter decrements each edge.
  - When the counter reaches 0 (edge N after start, N = latency), {HI,LO} receive the result and busy := 0 on that same edge.
  - The first cycle HI/LO show the new value is the cycle busy reads 0.
  - A new op may be accepted in that cycle.
- Arithmetic:
  - mult: {HI,LO} = signed 32x32 -> 64 product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundary cases:
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no trap.
  - Divisor = 0 (div or divu): runs full DIV_CYCLES, busy behaves normally, HI and LO keep their previous values.
- flush: only suppresses acceptance in the current cycle. An operation already in RUN completes and commits.
- start is asserted only in IDLE, never in RUN.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - md_op 0111 madd: {HI,LO} += signed product.
  - 1000 maddu: {HI,LO} += unsigned product.
  - 1001 msub: {HI,LO} -= signed product.
  - 1010 msubu: {HI,LO} -= unsigned product.
  - All use MULT_CYCLES latency, the same acceptance/busy rules and 64-bit wrap-around arithmetic.
  - The {HI,LO} accumulate base is HI/LO as of the commit edge.
- Not defined: codes 0111-1010 are treated as none (start=0, no state change).

Test Plan:
- Reset mid-op: reset while busy -> busy=0, HI=LO=0 next cycle, no late commit.
- mult 0xFFFFFFFF x 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE exactly 5 edges after start, busy high for 5 cycles. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 edges. div 0x80000000 / -1 -> LO=0x80000000, HI=0. divu 7/0 with prior HI=0x11, LO=0x22 -> values unchanged, busy drops after 10 cycles.
- mthi 0x12345678 while idle -> HI updates next edge, busy stays 0. mtlo presented while busy -> ignored, LO unchanged until the re-presented mtlo after busy drops.
- mult with flush=1 -> start=0, busy stays 0, HI/LO unchanged. Change ALU_RD1/ALU_RD2 mid-RUN -> result reflects the operands captured at start. Back-to-back mult in the completion cycle -> accepted, busy stays 1.
- (MD_MADD_EN) HI=0, LO=0xFFFFFFFF, maddu 1x1 -> HI=1, LO=0. Without the macro, md_op=0111 -> no start, no change.

Source files
------------

// File: rtl/md_if.sv
// md_if - EX-stage hookup between the pipeline and the multiply/divide unit.
//
// Signals:
//   md_op    operation presented in EX (4-bit code)
//   flush    EX instruction cancelled this cycle
//   ALU_RD1  forwarded rs value (multiplicand / dividend / mthi-mtlo source)
//   ALU_RD2  forwarded rt value (multiplier / divisor)
//   start    unit accepts a multiply/divide this cycle (combinational)
//   busy     an operation is in flight (registered)
//   HI, LO   architectural HI/LO registers
//
// Modports: master = pipeline side, slave = mult_div_unit side.
interface md_if;
    logic [3:0]  md_op;
    logic        flush;
    logic [31:0] ALU_RD1;
    logic [31:0] ALU_RD2;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output md_op, flush, ALU_RD1, ALU_RD2,
        input  start, busy, HI, LO
    );

    modport slave (
        input  md_op, flush, ALU_RD1, ALU_RD2,
        output start, busy, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit - EX-stage multiply/divide unit owning the HI/LO registers.
//
// Executes mult, multu, div, divu (multi-cycle) and mthi, mtlo (single cycle).
// The hazard unit uses start/busy to stall dependent instructions.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   md     md_if.slave bundle (md_op, flush, ALU_RD1, ALU_RD2 in;
//          start, busy, HI, LO out)
//
// Parameters:
//   MULT_CYCLES  edges from start to HI/LO update for multiplies (>= 1)
//   DIV_CYCLES   edges from start to HI/LO update for divides (>= 1)
//
// Optional feature macro MD_MADD_EN: adds madd/maddu/msub/msubu (codes
// 0111-1010) which accumulate into {HI,LO} with MULT_CYCLES latency. Without
// the macro those codes behave as "none".
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic        is_mult;
    logic        is_div;
    logic        accept_md;
    logic        accept_mthi;
    logic        accept_mtlo;
    logic        done;
    logic        commit;
    logic [63:0] result;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    // Classify the presented op into multiply-latency and divide-latency groups.
    always_comb begin
        is_mult = 1'b0;
        is_div  = 1'b0;
        case (md.md_op)
            OP_MULT, OP_MULTU: is_mult = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mult = 1'b1;
`endif
            OP_DIV, OP_DIVU:   is_div = 1'b1;
            default: ;
        endcase
    end

    // Anything presented while busy or flushed is dropped; the pipeline re-presents it.
    assign accept_md   = (state == IDLE) && !md.flush && (is_mult || is_div);
    assign accept_mthi = (state == IDLE) && !md.flush && (md.md_op == OP_MTHI);
    assign accept_mtlo = (state == IDLE) && !md.flush && (md.md_op == OP_MTLO);
    assign done        = (state == RUN) && (count == CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: leave RUN on the edge that commits the result.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept_md) next_state = RUN;
            RUN:  if (done)      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic for the handshake.
    always_comb begin
        md.start = accept_md;
        md.busy  = (state == RUN);
    end

    // Products: sign-extending to 64 bits makes the low 64 bits of the
    // product the signed result.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
    end

    // One unsigned divider serves both div and divu; for div the operands are
    // reduced to magnitudes and signs restored afterwards. This also gives
    // 0x80000000 / -1 = 0x80000000 remainder 0 with no special case.
    always_comb begin
        a_neg = (op_q == OP_DIV) && a_q[31];
        b_neg = (op_q == OP_DIV) && b_q[31];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        uq    = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
        ur    = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
        quot  = (a_neg ^ b_neg) ? -uq : uq;
        rem   = a_neg ? -ur : ur;
    end

    // Select the value written to {HI,LO} at the completion edge. A zero
    // divisor runs the full latency but leaves HI/LO untouched.
    always_comb begin
        result = {hi_q, lo_q};
        commit = 1'b0;
        case (op_q)
            OP_MULT:  begin result = prod_s;      commit = done; end
            OP_MULTU: begin result = prod_u;      commit = done; end
            OP_DIV,
            OP_DIVU:  begin result = {rem, quot}; commit = done && (b_q != 32'd0); end
`ifdef MD_MADD_EN
            OP_MADD:  begin result = {hi_q, lo_q} + prod_s; commit = done; end
            OP_MADDU: begin result = {hi_q, lo_q} + prod_u; commit = done; end
            OP_MSUB:  begin result = {hi_q, lo_q} - prod_s; commit = done; end
            OP_MSUBU: begin result = {hi_q, lo_q} - prod_u; commit = done; end
`endif
            default: ;
        endcase
    end

    // Operand capture, countdown and HI/LO updates. Commits only happen in
    // RUN and mthi/mtlo only in IDLE, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (accept_md) begin
                op_q  <= md.md_op;
                a_q   <= md.ALU_RD1;
                b_q   <= md.ALU_RD2;
                count <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (state == RUN) begin
                count <= count - CNT_W'(1);
            end

            if (commit) begin
                {hi_q, lo_q} <= result;
            end else if (accept_mthi) begin
                hi_q <= md.ALU_RD1;
            end else if (accept_mtlo) begin
                lo_q <= md.ALU_RD1;
            end
        end
    end

    assign md.HI = hi_q;
    assign md.LO = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit - self-checking bench for mult_div_unit.
//
// Drives the unit through an md_if instance: a table of fixed vectors with
// hand-computed results, hand-written sequences for multi-cycle corner cases,
// and a randomized run compared against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_if intf();

    mult_div_unit #(
        .MULT_CYCLES(MULT_LAT),
        .DIV_CYCLES (DIV_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (intf)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runaway guard so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic fl);
        intf.md_op   = op;
        intf.ALU_RD1 = a;
        intf.ALU_RD2 = b;
        intf.flush   = fl;
    endtask

    function automatic int latencyOf(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: return MULT_LAT;
            OP_DIV, OP_DIVU:   return DIV_LAT;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MULT_LAT;
`endif
            default: return 0;
        endcase
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural effect.
    task automatic modelApply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {m_hi, m_lo};
        case (op)
            OP_MULT:  {m_hi, m_lo} = 64'(sa * sb);
            OP_MULTU: {m_hi, m_lo} = 64'(ua * ub);
            OP_DIV:   if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            OP_DIVU:  if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
            OP_MTHI:  m_hi = a;
            OP_MTLO:  m_lo = a;
`ifdef MD_MADD_EN
            OP_MADD:  {m_hi, m_lo} = acc + 64'(sa * sb);
            OP_MADDU: {m_hi, m_lo} = acc + 64'(ua * ub);
            OP_MSUB:  {m_hi, m_lo} = acc - 64'(sa * sb);
            OP_MSUBU: {m_hi, m_lo} = acc - 64'(ua * ub);
`endif
            default: ;
        endcase
    endtask

    // Wait (bounded) for busy to fall, counting edges since the accept edge.
    task automatic waitIdle(output int cyc);
        cyc = 0;
        while (intf.busy === 1'b1 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Issue one op from an idle unit, scramble operands after acceptance,
    // then check latency and final HI/LO against the model.
    task automatic runOp(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string name);
        int lat;
        int cyc;
        lat = latencyOf(op);
        applyStimulus(op, a, b, 1'b0);
        #1;
        checkOutput({name, " start"}, 32'(intf.start), (lat > 0) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(OP_NONE, $urandom, $urandom, 1'b0);
        modelApply(op, a, b);
        if (lat > 0) begin
            waitIdle(cyc);
            checkOutput({name, " latency"}, 32'(cyc), 32'(lat));
        end else begin
            checkOutput({name, " busy"}, 32'(intf.busy), 32'd0);
        end
        checkOutput({name, " HI"}, intf.HI, m_hi);
        checkOutput({name, " LO"}, intf.LO, m_lo);
    endtask

    initial begin
        vec_t vecs[8];
        int   cyc;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult -1x2"};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, "multu"};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
        vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"};
        vecs[4] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu 100/7"};
        vecs[5] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, "mult max"};
        vecs[6] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu big"};
        vecs[7] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};

        total = 0;
        bad   = 0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        reset = 1'b1;
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset HI", intf.HI, 32'd0);
        checkOutput("reset LO", intf.LO, 32'd0);
        checkOutput("reset busy", 32'(intf.busy), 32'd0);
        checkOutput("reset start", 32'(intf.start), 32'd0);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name);
            checkOutput({vecs[i].name, " HI const"}, intf.HI, vecs[i].hi);
            checkOutput({vecs[i].name, " LO const"}, intf.LO, vecs[i].lo);
        end

        $display("[TB] divide by zero keeps HI/LO");
        runOp(OP_MTHI, 32'h11, 32'd0, "mthi 11");
        runOp(OP_MTLO, 32'h22, 32'd0, "mtlo 22");
        runOp(OP_DIVU, 32'd7, 32'd0, "divu 7/0");
        checkOutput("div0 HI const", intf.HI, 32'h11);
        checkOutput("div0 LO const", intf.LO, 32'h22);

        $display("[TB] mthi while idle");
        runOp(OP_MTHI, 32'h12345678, 32'd0, "mthi");
        checkOutput("mthi HI const", intf.HI, 32'h12345678);

        $display("[TB] mtlo while busy");
        applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b0);
        @(posedge clk);
        #1;
        modelApply(OP_MULT, 32'd3, 32'd4);
        applyStimulus(OP_MTLO, 32'h0000AAAA, 32'd0, 1'b0);
        checkOutput("mtlo busy start", 32'(intf.start), 32'd0);
        waitIdle(cyc);
        checkOutput("mtlo busy latency", 32'(cyc), 32'(MULT_LAT));
        checkOutput("mtlo busy LO held", intf.LO, 32'd12);
        @(posedge clk);
        #1;
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        modelApply(OP_MTLO, 32'h0000AAAA, 32'd0);
        checkOutput("mtlo represented LO", intf.LO, 32'h0000AAAA);
        checkOutput("mtlo represented HI", intf.HI, m_hi);

        $display("[TB] flushed mult");
        applyStimulus(OP_MULT, 32'd5, 32'd6, 1'b1);
        #1;
        checkOutput("flush start", 32'(intf.start), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        checkOutput("flush busy", 32'(intf.busy), 32'd0);
        checkOutput("flush HI", intf.HI, m_hi);
        checkOutput("flush LO", intf.LO, m_lo);

        $display("[TB] back-to-back mult");
        applyStimulus(OP_MULT, 32'd3, 32'd5, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        waitIdle(cyc);
        checkOutput("b2b first LO", intf.LO, 32'd15);
        applyStimulus(OP_MULT, 32'd6, 32'd7, 1'b0);
        #1;
        checkOutput("b2b start", 32'(intf.start), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(OP_NONE, 32'd9, 32'd9, 1'b0);
        checkOutput("b2b busy", 32'(intf.busy), 32'd1);
        waitIdle(cyc);
        checkOutput("b2b latency", 32'(cyc), 32'(MULT_LAT));
        checkOutput("b2b LO", intf.LO, 32'd42);
        checkOutput("b2b HI", intf.HI, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd42;

        $display("[TB] reset mid-op");
        runOp(OP_MTHI, 32'h55, 32'd0, "pre-reset mthi");
        applyStimulus(OP_DIV, 32'd100, 32'd3, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checkOutput("midreset busy", 32'(intf.busy), 32'd0);
        checkOutput("midreset HI", intf.HI, 32'd0);
        checkOutput("midreset LO", intf.LO, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("midreset late HI", intf.HI, 32'd0);
        checkOutput("midreset late LO", intf.LO, 32'd0);

`ifdef MD_MADD_EN
        $display("[TB] maddu carry");
        runOp(OP_MTHI, 32'd0, 32'd0, "madd mthi");
        runOp(OP_MTLO, 32'hFFFFFFFF, 32'd0, "madd mtlo");
        runOp(OP_MADDU, 32'd1, 32'd1, "maddu 1x1");
        checkOutput("maddu HI const", intf.HI, 32'd1);
        checkOutput("maddu LO const", intf.LO, 32'd0);
`else
        $display("[TB] code 0111 is none");
        runOp(OP_MTHI, 32'h77, 32'd0, "pre-0111 mthi");
        applyStimulus(OP_MADD, 32'd3, 32'd4, 1'b0);
        #1;
        checkOutput("op7 start", 32'(intf.start), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        checkOutput("op7 busy", 32'(intf.busy), 32'd0);
        checkOutput("op7 HI", intf.HI, m_hi);
        checkOutput("op7 LO", intf.LO, m_lo);
`endif

        $display("[TB] randomized ops");
        for (int i = 0; i < 40; i++) begin
`ifdef MD_MADD_EN
            rop = 4'($urandom_range(1, 10));
`else
            rop = 4'($urandom_range(1, 6));
`endif
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            runOp(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
